ahbslv_mem: RTL and testbench

AHB slave responder that terminates the transfers issued by the rotate core's AHB master interface. It provides word-organised local memory for the image/line buffer, with byte-lane writes selected by HSIZE and HADDR[1:0]. It also inserts programmable wait states and returns two-cycle ERROR responses. It sits on the AHB data bus behind the decoder, which drives HSEL.

---
 rtl/ahb_pkg.sv | 50 +++++
 rtl/ahbslv_ram.sv | 22 ++
 rtl/ahbslv_mem.sv | 151 +++++++++++++++
 tb/tb_ahbslv_mem.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the slave FSM state type for the ahbslv_mem responder.
// Optional boundary check is enabled in ahbslv_mem by defining AHBSLV_BOUNDARY_CHK_EN.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE = 2'b00;
   localparam logic [1:0] HTRANS_BUSY = 2'b01;
   localparam logic [1:0] HTRANS_NSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ  = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA,
      S_ERR1,
      S_ERR2
   } ahb_state_e;

   typedef struct packed {
      ahb_state_e state;
      logic [2:0] hburst;
      logic [3:0] wait_cnt;
      logic       htrans_lsb;
   } ahb_dbg_t;

   // Little-endian byte-lane enables for an aligned transfer.
   function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lsb);
      case (size)
         HSIZE_BYTE: lane_mask = 4'b0001 << lsb;
         HSIZE_HALF: lane_mask = lsb[1] ? 4'b1100 : 4'b0011;
         default:    lane_mask = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/ahbslv_ram.sv
// Word-organised local memory: byte-enable synchronous write, asynchronous read.
module ahbslv_ram #(
   parameter int P_ADDR_W = 10
) (
   input  logic                clk,
   input  logic [3:0]          be,
   input  logic [P_ADDR_W-1:0] addr,
   input  logic [31:0]         wdata,
   output logic [31:0]         rdata
);

   logic [31:0] mem_q [2**P_ADDR_W];

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/ahbslv_mem.sv
// AHB slave responder with local memory, programmable wait states and two-cycle ERROR.
// Define AHBSLV_BOUNDARY_CHK_EN to reject SEQ transfers that start on a 1 KB boundary.
module ahbslv_mem
   import ahb_pkg::*;
#(
   parameter int P_ADDR_W = 10,
   parameter int P_WAIT   = 0
) (
   input  logic        I_AHBSLV_HCLK,
   input  logic        I_AHBSLV_HRESET_N,
   input  logic        I_AHBSLV_HSEL,
   input  logic [31:0] I_AHBSLV_HADDR,
   input  logic        I_AHBSLV_HWRITE,
   input  logic [1:0]  I_AHBSLV_HTRANS,
   input  logic [2:0]  I_AHBSLV_HSIZE,
   input  logic [2:0]  I_AHBSLV_HBURST,
   input  logic [31:0] I_AHBSLV_HWDATA,
   input  logic        I_AHBSLV_HREADY,
   output logic        O_AHBSLV_HREADYOUT,
   output logic [1:0]  O_AHBSLV_HRESP,
   output logic [31:0] O_AHBSLV_HRDATA,
   output logic [15:0] O_AHBSLV_XFER_CNT
);

   localparam int         AW        = P_ADDR_W + 2;
   localparam logic [3:0] WAIT_LOAD = (P_WAIT > 0) ? 4'(P_WAIT - 1) : 4'd0;

   ahb_state_e    state_q, state_d;
   logic [3:0]    wait_q, wait_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          write_q, write_d;
   logic [2:0]    size_q, size_d;
   logic [2:0]    burst_q, burst_d;
   logic [15:0]   cnt_q, cnt_d;

   logic          sample;
   logic          addr_err;
   logic          accept;
   logic [3:0]    ram_be;
   logic [31:0]   ram_rdata;
   ahb_dbg_t      dbg_unused;

   assign sample = I_AHBSLV_HSEL & I_AHBSLV_HREADY & I_AHBSLV_HTRANS[1];

   always_comb begin
      addr_err = 1'b0;
      if (I_AHBSLV_HSIZE > HSIZE_WORD) addr_err = 1'b1;
      if ((I_AHBSLV_HSIZE == HSIZE_HALF) && I_AHBSLV_HADDR[0]) addr_err = 1'b1;
      if ((I_AHBSLV_HSIZE == HSIZE_WORD) && (I_AHBSLV_HADDR[1:0] != 2'b00)) addr_err = 1'b1;
      if ((I_AHBSLV_HADDR >> AW) != 32'd0) addr_err = 1'b1;
`ifdef AHBSLV_BOUNDARY_CHK_EN
      if ((I_AHBSLV_HTRANS == HTRANS_SEQ) && (I_AHBSLV_HADDR[9:0] == 10'd0)) addr_err = 1'b1;
`endif
   end

   always_comb begin
      state_d            = state_q;
      wait_d             = wait_q;
      addr_d             = addr_q;
      write_d            = write_q;
      size_d             = size_q;
      burst_d            = burst_q;
      cnt_d              = cnt_q;
      accept             = 1'b0;
      ram_be             = 4'b0000;
      O_AHBSLV_HREADYOUT = 1'b1;
      O_AHBSLV_HRESP     = HRESP_OKAY;
      O_AHBSLV_HRDATA    = 32'd0;

      case (state_q)
         S_IDLE: accept = 1'b1;
         S_WAIT: begin
            O_AHBSLV_HREADYOUT = 1'b0;
            if (wait_q == 4'd0) state_d = S_DATA;
            else                wait_d  = wait_q - 4'd1;
         end
         S_DATA: begin
            accept = 1'b1;
            if (write_q) ram_be = lane_mask(size_q, addr_q[1:0]);
            else         O_AHBSLV_HRDATA = ram_rdata;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
         end
         S_ERR1: begin
            O_AHBSLV_HREADYOUT = 1'b0;
            O_AHBSLV_HRESP     = HRESP_ERROR;
            state_d            = S_ERR2;
         end
         S_ERR2: begin
            O_AHBSLV_HRESP = HRESP_ERROR;
            accept         = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // Cycles that end with HREADYOUT high may also carry the next address phase.
      if (accept) begin
         state_d = S_IDLE;
         if (sample) begin
            addr_d  = I_AHBSLV_HADDR[AW-1:0];
            write_d = I_AHBSLV_HWRITE;
            size_d  = I_AHBSLV_HSIZE;
            burst_d = I_AHBSLV_HBURST;
            if (addr_err) begin
               state_d = S_ERR1;
            end else if (P_WAIT > 0) begin
               state_d = S_WAIT;
               wait_d  = WAIT_LOAD;
            end else begin
               state_d = S_DATA;
            end
         end
      end
   end

   always_ff @(posedge I_AHBSLV_HCLK or negedge I_AHBSLV_HRESET_N) begin
      if (!I_AHBSLV_HRESET_N) begin
         state_q <= S_IDLE;
         wait_q  <= 4'd0;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= 3'd0;
         burst_q <= 3'd0;
         cnt_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         size_q  <= size_d;
         burst_q <= burst_d;
         cnt_q   <= cnt_d;
      end
   end

   assign O_AHBSLV_XFER_CNT = cnt_q;

   // Snapshot for hierarchical debug probes; HBURST is kept only for this.
   assign dbg_unused = '{state: state_q, hburst: burst_q, wait_cnt: wait_q,
                         htrans_lsb: I_AHBSLV_HTRANS[0]};

   ahbslv_ram #(
      .P_ADDR_W(P_ADDR_W)
   ) u_ram (
      .clk  (I_AHBSLV_HCLK),
      .be   (ram_be),
      .addr (addr_q[AW-1:2]),
      .wdata(I_AHBSLV_HWDATA),
      .rdata(ram_rdata)
   );

endmodule

// File: tb/tb_ahbslv_mem.sv
// Bench for ahbslv_mem: two slaves (P_WAIT=0 and P_WAIT=2) on one bus, a transaction-level
// memory model, and a monitor that checks each data phase against an expected queue.
module tb_ahbslv_mem;

   localparam logic [1:0] T_IDLE = 2'b00;
   localparam logic [1:0] T_BUSY = 2'b01;
   localparam logic [1:0] T_NSEQ = 2'b10;
   localparam logic [1:0] T_SEQ  = 2'b11;
   localparam int         EXP_W  = 38;
`ifdef AHBSLV_BOUNDARY_CHK_EN
   localparam bit BOUNDARY = 1'b1;
`else
   localparam bit BOUNDARY = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        hsel, hwrite, sel;
   logic [31:0] haddr, hwdata;
   logic [1:0]  htrans;
   logic [2:0]  hsize, hburst;
   logic        ro0, ro2, hready_bus;
   logic [1:0]  resp0, resp2, resp_bus;
   logic [31:0] rd0, rd2, rdata_bus;
   logic [15:0] cnt0, cnt2;

   assign hready_bus = sel ? ro2 : ro0;
   assign resp_bus   = sel ? resp2 : resp0;
   assign rdata_bus  = sel ? rd2 : rd0;

   ahbslv_mem #(.P_ADDR_W(10), .P_WAIT(0)) dut_w0 (
      .I_AHBSLV_HCLK(clk), .I_AHBSLV_HRESET_N(rst_n), .I_AHBSLV_HSEL(hsel & ~sel),
      .I_AHBSLV_HADDR(haddr), .I_AHBSLV_HWRITE(hwrite), .I_AHBSLV_HTRANS(htrans),
      .I_AHBSLV_HSIZE(hsize), .I_AHBSLV_HBURST(hburst), .I_AHBSLV_HWDATA(hwdata),
      .I_AHBSLV_HREADY(hready_bus), .O_AHBSLV_HREADYOUT(ro0), .O_AHBSLV_HRESP(resp0),
      .O_AHBSLV_HRDATA(rd0), .O_AHBSLV_XFER_CNT(cnt0));

   ahbslv_mem #(.P_ADDR_W(10), .P_WAIT(2)) dut_w2 (
      .I_AHBSLV_HCLK(clk), .I_AHBSLV_HRESET_N(rst_n), .I_AHBSLV_HSEL(hsel & sel),
      .I_AHBSLV_HADDR(haddr), .I_AHBSLV_HWRITE(hwrite), .I_AHBSLV_HTRANS(htrans),
      .I_AHBSLV_HSIZE(hsize), .I_AHBSLV_HBURST(hburst), .I_AHBSLV_HWDATA(hwdata),
      .I_AHBSLV_HREADY(hready_bus), .O_AHBSLV_HREADYOUT(ro2), .O_AHBSLV_HRESP(resp2),
      .O_AHBSLV_HRDATA(rd2), .O_AHBSLV_XFER_CNT(cnt2));

   // ---------------- reference model + scoreboard ----------------
   logic [31:0]      mdl [2][1024];
   int               cnt_m [2];
   logic [EXP_W-1:0] exp_q [$];   // {waits[3:0], is_read, err, rdata[31:0]}
   int               n_cmp = 0;
   int               n_bad = 0;
   int               dp_cycles = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic logic ref_err(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] sz);
      int nb;
      if (sz > 3'd2) return 1'b1;
      nb = 1 << sz;
      if ((a % nb) != 0) return 1'b1;
      if (a >= 32'h0000_1000) return 1'b1;
      if (BOUNDARY && (tr == T_SEQ) && ((a % 1024) == 0)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] bus,
                                         input logic [31:0] a, input logic [2:0] sz);
      logic [31:0] r;
      int first, nb;
      r = old;
      nb = 1 << sz;
      first = int'(a[1:0]);
      for (int b = 0; b < 4; b++)
         if (b >= first && b < first + nb) r[8*b +: 8] = bus[8*b +: 8];
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd);
      logic        err;
      logic [31:0] rexp;
      int          d, n;
      d = sel ? 1 : 0;
      hsel = 1'b1; htrans = tr; hwrite = wr; haddr = a; hsize = sz;
      n = 0;
      forever begin
         @(negedge clk);
         if (hready_bus) break;
         n++;
         if (n > 40) begin
            n_cmp++; n_bad++;
            $display("FAIL addr_phase_timeout: got hready=0 for %0d cycles expected 1", n);
            break;
         end
      end
      err  = ref_err(tr, a, sz);
      rexp = 32'd0;
      if (!err) begin
         if (wr) mdl[d][a[11:2]] = merge(mdl[d][a[11:2]], wd, a, sz);
         else    rexp = mdl[d][a[11:2]];
         cnt_m[d]++;
      end
      exp_q.push_back({err ? 4'd1 : (sel ? 4'd2 : 4'd0), ~wr, err, rexp});
      @(posedge clk); #1;
      hwdata = wd;
      hsel = 1'b0; htrans = T_IDLE;
   endtask

   task automatic drain();
      hsel = 1'b0; htrans = T_IDLE;
      repeat (6) @(posedge clk);
      #1;
      chk("xfer_cnt_w0", 32'(cnt0), 32'(cnt_m[0]));
      chk("xfer_cnt_w2", 32'(cnt2), 32'(cnt_m[1]));
   endtask

   task automatic gap();
      case ($urandom_range(0, 2))
         0: begin hsel = 1'b0; htrans = T_IDLE; end
         1: begin hsel = 1'b1; htrans = T_BUSY; end
         default: begin hsel = 1'b0; htrans = T_NSEQ; haddr = 32'($urandom_range(0, 63)); end
      endcase
      @(posedge clk); #1;
      hsel = 1'b0; htrans = T_IDLE;
   endtask

   task automatic rnd_xfer();
      int          r;
      logic [2:0]  sz;
      logic [31:0] a;
      r  = $urandom_range(0, 15);
      sz = (r == 1) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 63));
      if (r != 2 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
      if (r == 3) a = a | 32'h0000_1000;
      if (r == 4) a = a | (32'($urandom_range(1, 255)) << 24);
      issue(($urandom_range(0, 1) == 1) ? T_SEQ : T_NSEQ, 1'($urandom_range(0, 1)), a, sz, $urandom());
   endtask

   // ---------------- monitor ----------------
   logic dp_active = 1'b0;
   int   wcnt = 0;

   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      if (!rst_n) begin
         dp_active = 1'b0;
         wcnt = 0;
      end else begin
         if (dp_active) begin
            dp_cycles++;
            if (exp_q.size() == 0) begin
               chk("orphan_data_phase", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q[0];
               chk("hresp", 32'(resp_bus), 32'(e[32]));
               if (!hready_bus) begin
                  wcnt++;
               end else begin
                  e = exp_q.pop_front();
                  chk("wait_states", 32'(wcnt), 32'(e[37:34]));
                  chk("hrdata", rdata_bus, e[31:0]);
                  wcnt = 0;
               end
            end
         end
         if (hready_bus) dp_active = hsel && htrans[1];
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before 1 ms");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] old_v;
      hsel = 1'b0; htrans = T_IDLE; hwrite = 1'b0; haddr = 32'd0; hsize = 3'd2;
      hburst = 3'd0; hwdata = 32'd0; sel = 1'b0;
      cnt_m[0] = 0; cnt_m[1] = 0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hreadyout_w0", 32'(ro0), 32'd1);
      chk("rst_hreadyout_w2", 32'(ro2), 32'd1);
      chk("rst_hresp_w0", 32'(resp0), 32'd0);
      chk("rst_hresp_w2", 32'(resp2), 32'd0);
      chk("rst_hrdata_w0", rd0, 32'd0);
      chk("rst_hrdata_w2", rd2, 32'd0);
      chk("rst_cnt_w0", 32'(cnt0), 32'd0);
      chk("rst_cnt_w2", 32'(cnt2), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Zero-wait write then read of the same word.
      issue(T_NSEQ, 1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF);
      issue(T_NSEQ, 1'b0, 32'h10, 3'd2, 32'd0);
      drain();
      chk("t1_xfer_cnt", 32'(cnt0), 32'd2);

      // Byte and half lanes merged into a cleared word.
      issue(T_NSEQ, 1'b1, 32'h10, 3'd2, 32'h0000_0000);
      issue(T_NSEQ, 1'b1, 32'h11, 3'd0, 32'h0000_AA00);
      issue(T_NSEQ, 1'b1, 32'h12, 3'd1, 32'h5566_0000);
      issue(T_NSEQ, 1'b0, 32'h10, 3'd2, 32'd0);
      drain();
      chk("t2_lane_model", mdl[0][4], 32'h5566_AA00);

      // Zero-wait back-to-back burst: one beat per cycle.
      dp_cycles = 0;
      for (int i = 0; i < 4; i++)
         issue((i == 0) ? T_NSEQ : T_SEQ, 1'b1, 32'h40 + 32'(4 * i), 3'd2, $urandom());
      drain();
      chk("w0_burst_cycles", 32'(dp_cycles), 32'd4);

      // Two wait states per beat on an INCR4 read.
      sel = 1'b1;
      for (int i = 0; i < 4; i++) issue(T_NSEQ, 1'b1, 32'h20 + 32'(4 * i), 3'd2, $urandom());
      drain();
      dp_cycles = 0;
      hburst = 3'b011;
      for (int i = 0; i < 4; i++)
         issue((i == 0) ? T_NSEQ : T_SEQ, 1'b0, 32'h20 + 32'(4 * i), 3'd2, 32'd0);
      drain();
      hburst = 3'b000;
      chk("incr4_cycles", 32'(dp_cycles), 32'd12);

      // Misaligned word write must not touch memory or the counter.
      sel = 1'b0;
      issue(T_NSEQ, 1'b1, 32'h0, 3'd2, 32'h1122_3344);
      issue(T_NSEQ, 1'b1, 32'h2, 3'd2, 32'hFFFF_FFFF);
      issue(T_NSEQ, 1'b0, 32'h0, 3'd2, 32'd0);
      drain();

      // Out-of-range address and the 1 KB boundary.
      issue(T_NSEQ, 1'b0, 32'h1000, 3'd2, 32'd0);
      issue(T_NSEQ, 1'b1, 32'h400, 3'd2, 32'hA5A5_0001);
      issue(T_NSEQ, 1'b1, 32'h3FC, 3'd2, 32'hA5A5_0002);
      issue(T_SEQ,  1'b1, 32'h400, 3'd2, 32'hA5A5_0003);
      issue(T_NSEQ, 1'b0, 32'h400, 3'd2, 32'd0);
      issue(T_NSEQ, 1'b0, 32'h3FC, 3'd2, 32'd0);
      drain();

      // Reset during the wait states of a write: the write is dropped.
      sel = 1'b1;
      issue(T_NSEQ, 1'b1, 32'h30, 3'd2, 32'h0BAD_F00D);
      drain();
      old_v = mdl[1][12];
      issue(T_NSEQ, 1'b1, 32'h30, 3'd2, 32'h1357_9BDF);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_hreadyout", 32'(ro2), 32'd1);
      chk("midrst_hresp", 32'(resp2), 32'd0);
      chk("midrst_hrdata", rd2, 32'd0);
      chk("midrst_cnt_w2", 32'(cnt2), 32'd0);
      chk("midrst_cnt_w0", 32'(cnt0), 32'd0);
      exp_q.delete();
      mdl[1][12] = old_v;
      cnt_m[0] = 0; cnt_m[1] = 0;
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      issue(T_NSEQ, 1'b0, 32'h30, 3'd2, 32'd0);
      drain();

      // Randomized traffic over a pre-initialised window on both slaves.
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         for (int w = 0; w < 16; w++) issue(T_NSEQ, 1'b1, 32'(4 * w), 3'd2, $urandom());
         drain();
      end
      for (int bt = 0; bt < 10; bt++) begin
         sel = 1'($urandom_range(0, 1));
         for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 5) == 0) gap();
            else rnd_xfer();
         end
         drain();
      end

      chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
